// File: rtl/mips_ctrl.sv
// Multicycle sequencing FSM for the MIPS subset core: decodes op/ZF/dm_ready
// into datapath mux selects and write enables, plus cycle/retire counters.
module mips_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [2:0]       op,
    input  logic             ZF,
    input  logic             dm_ready,
    output logic             PCWr,
    output logic             IRWr,
    output logic             ABWr,
    output logic             TgtWr,
    output logic             ALUoutWr,
    output logic             DRWr,
    output logic             DMWr,
    output logic             RFWr,
    output logic             extSZ,
    output logic             alu_A_sel,
    output logic [1:0]       alu_B_sel,
    output logic [1:0]       alu_ctrl,
    output logic [1:0]       rf_W_sel,
    output logic [1:0]       rf_din_sel,
    output logic [1:0]       pc_sel,
    output logic [3:0]       state_o,
    output logic             illegal_op,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] inst_cnt
);

    typedef enum logic [3:0] {
        S_INST_FETCH = 4'd0,
        S_DECODE     = 4'd1,
        S_MEM_CALC   = 4'd2,
        S_MEM_LOAD   = 4'd3,
        S_MEM_WRITE  = 4'd4,
        S_REG_WRITE  = 4'd5,
        S_R_EXEC     = 4'd6,
        S_R_FINISH   = 4'd7,
        S_OR_EXEC    = 4'd8,
        S_OR_FINISH  = 4'd9,
        S_BR_FINISH  = 4'd10,
        S_JA_FINISH  = 4'd11
    } state_t;

    localparam logic [2:0] OP_ADDU = 3'd0;
    localparam logic [2:0] OP_SUBU = 3'd1;
    localparam logic [2:0] OP_ORI  = 3'd2;
    localparam logic [2:0] OP_LW   = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_BEQ  = 3'd5;
    localparam logic [2:0] OP_JAL  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;

    logic pc_wr, ir_wr, ab_wr, tgt_wr, aluout_wr, dr_wr, dm_wr, rf_wr;
    logic illegal;
    logic retire;

    // dm_ready is a level-sensitive completion handshake: the FSM holds in
    // MemLoad/MemWrite with the request asserted until dm_ready=1 is sampled.
    always_comb begin
        state_d    = S_INST_FETCH;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        ab_wr      = 1'b0;
        tgt_wr     = 1'b0;
        aluout_wr  = 1'b0;
        dr_wr      = 1'b0;
        dm_wr      = 1'b0;
        rf_wr      = 1'b0;
        extSZ      = 1'b0;
        alu_A_sel  = 1'b0;
        alu_B_sel  = 2'd0;
        alu_ctrl   = 2'd0;
        rf_W_sel   = 2'd0;
        rf_din_sel = 2'd0;
        pc_sel     = 2'd0;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            S_INST_FETCH: begin
                if (run) begin
                    state_d = S_DECODE;
                    pc_wr   = 1'b1;
                    ir_wr   = 1'b1;
                    pc_sel  = 2'd1;
                end else begin
                    state_d = S_INST_FETCH;
                end
            end
            S_DECODE: begin
                ab_wr     = 1'b1;
                tgt_wr    = 1'b1;
                alu_B_sel = 2'd2;
                extSZ     = 1'b1;
                case (op)
                    OP_ADDU, OP_SUBU: state_d = S_R_EXEC;
                    OP_ORI:           state_d = S_OR_EXEC;
                    OP_LW, OP_SW:     state_d = S_MEM_CALC;
                    OP_BEQ:           state_d = S_BR_FINISH;
                    OP_JAL:           state_d = S_JA_FINISH;
                    default: begin
                        state_d = S_INST_FETCH;
                        illegal = (op == OP_ILL);
                    end
                endcase
            end
            S_MEM_CALC: begin
                state_d   = (op == OP_SW) ? S_MEM_WRITE : S_MEM_LOAD;
                aluout_wr = 1'b1;
                alu_A_sel = 1'b1;
                alu_B_sel = 2'd3;
                extSZ     = 1'b1;
            end
            S_MEM_LOAD: begin
                state_d = dm_ready ? S_REG_WRITE : S_MEM_LOAD;
                dr_wr   = dm_ready;
            end
            S_MEM_WRITE: begin
                state_d = dm_ready ? S_INST_FETCH : S_MEM_WRITE;
                dm_wr   = 1'b1;
                retire  = dm_ready;
            end
            S_REG_WRITE: begin
                rf_wr  = 1'b1;
                retire = 1'b1;
            end
            S_R_EXEC: begin
                state_d   = S_R_FINISH;
                aluout_wr = 1'b1;
                alu_A_sel = 1'b1;
                alu_B_sel = 2'd1;
                alu_ctrl  = (op == OP_SUBU) ? 2'd1 : 2'd0;
            end
            S_R_FINISH: begin
                rf_wr      = 1'b1;
                rf_W_sel   = 2'd1;
                rf_din_sel = 2'd1;
                retire     = 1'b1;
            end
            S_OR_EXEC: begin
                state_d   = S_OR_FINISH;
                aluout_wr = 1'b1;
                alu_A_sel = 1'b1;
                alu_B_sel = 2'd3;
                alu_ctrl  = 2'd2;
            end
            S_OR_FINISH: begin
                rf_wr      = 1'b1;
                rf_din_sel = 2'd1;
                retire     = 1'b1;
            end
            S_BR_FINISH: begin
                alu_A_sel = 1'b1;
                alu_B_sel = 2'd1;
                alu_ctrl  = 2'd1;
                pc_wr     = ZF;
                retire    = 1'b1;
            end
            S_JA_FINISH: begin
                rf_wr      = 1'b1;
                rf_W_sel   = 2'd2;
                rf_din_sel = 2'd2;
                pc_wr      = 1'b1;
                pc_sel     = 2'd2;
                retire     = 1'b1;
            end
            default: state_d = S_INST_FETCH;
        endcase

        cyc_cnt_d  = cyc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        inst_cnt_d = inst_cnt_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_INST_FETCH;
            cyc_cnt_q  <= '0;
            inst_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cyc_cnt_q  <= cyc_cnt_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    // Holding rst low suppresses every side effect, so an abandoned
    // instruction cannot write anything on the reset edge.
    assign PCWr       = rst & pc_wr;
    assign IRWr       = rst & ir_wr;
    assign ABWr       = rst & ab_wr;
    assign TgtWr      = rst & tgt_wr;
    assign ALUoutWr   = rst & aluout_wr;
    assign DRWr       = rst & dr_wr;
    assign DMWr       = rst & dm_wr;
    assign RFWr       = rst & rf_wr;
    assign illegal_op = rst & illegal;
    assign state_o    = state_q;
    assign cyc_cnt    = cyc_cnt_q;
    assign inst_cnt   = inst_cnt_q;

endmodule

// File: tb/tb_mips_ctrl.sv
// Directed bench for mips_ctrl: per-cycle expected control words are queued
// by the driver and checked by an independent negedge monitor.
module tb_mips_ctrl;

    localparam int W = 89;

    logic clk;
    logic rst;
    logic run;
    logic [2:0] op;
    logic ZF;
    logic dm_ready;

    logic PCWr, IRWr, ABWr, TgtWr, ALUoutWr, DRWr, DMWr, RFWr;
    logic extSZ, alu_A_sel, illegal_op;
    logic [1:0] alu_B_sel, alu_ctrl, rf_W_sel, rf_din_sel, pc_sel;
    logic [3:0] state_o;
    logic [31:0] cyc_cnt, inst_cnt;

    logic PCWr_w, IRWr_w, ABWr_w, TgtWr_w, ALUoutWr_w, DRWr_w, DMWr_w, RFWr_w;
    logic extSZ_w, alu_A_sel_w, illegal_op_w;
    logic [1:0] alu_B_sel_w, alu_ctrl_w, rf_W_sel_w, rf_din_sel_w, pc_sel_w;
    logic [3:0] state_o_w;
    logic [3:0] cyc_cnt_w, inst_cnt_w;

    mips_ctrl #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .run(run), .op(op), .ZF(ZF), .dm_ready(dm_ready),
        .PCWr(PCWr), .IRWr(IRWr), .ABWr(ABWr), .TgtWr(TgtWr),
        .ALUoutWr(ALUoutWr), .DRWr(DRWr), .DMWr(DMWr), .RFWr(RFWr),
        .extSZ(extSZ), .alu_A_sel(alu_A_sel), .alu_B_sel(alu_B_sel),
        .alu_ctrl(alu_ctrl), .rf_W_sel(rf_W_sel), .rf_din_sel(rf_din_sel),
        .pc_sel(pc_sel), .state_o(state_o), .illegal_op(illegal_op),
        .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
    );

    // Narrow-counter build: wraps every 16 cycles during the run.
    mips_ctrl #(.CNT_W(4)) u_dut_w4 (
        .clk(clk), .rst(rst), .run(run), .op(op), .ZF(ZF), .dm_ready(dm_ready),
        .PCWr(PCWr_w), .IRWr(IRWr_w), .ABWr(ABWr_w), .TgtWr(TgtWr_w),
        .ALUoutWr(ALUoutWr_w), .DRWr(DRWr_w), .DMWr(DMWr_w), .RFWr(RFWr_w),
        .extSZ(extSZ_w), .alu_A_sel(alu_A_sel_w), .alu_B_sel(alu_B_sel_w),
        .alu_ctrl(alu_ctrl_w), .rf_W_sel(rf_W_sel_w), .rf_din_sel(rf_din_sel_w),
        .pc_sel(pc_sel_w), .state_o(state_o_w), .illegal_op(illegal_op_w),
        .cyc_cnt(cyc_cnt_w), .inst_cnt(inst_cnt_w)
    );

    logic [24:0] ctrl_m, ctrl_w;
    assign ctrl_m = {state_o, PCWr, IRWr, ABWr, TgtWr, ALUoutWr, DRWr, DMWr, RFWr,
                     extSZ, alu_A_sel, alu_B_sel, alu_ctrl, rf_W_sel, rf_din_sel,
                     pc_sel, illegal_op};
    assign ctrl_w = {state_o_w, PCWr_w, IRWr_w, ABWr_w, TgtWr_w, ALUoutWr_w,
                     DRWr_w, DMWr_w, RFWr_w, extSZ_w, alu_A_sel_w, alu_B_sel_w,
                     alu_ctrl_w, rf_W_sel_w, rf_din_sel_w, pc_sel_w, illegal_op_w};

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           total = 0;
    int           bad = 0;
    logic [31:0]  cyc_m = '0;
    logic [31:0]  inst_m = '0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard monitor ----------------
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_got;
    logic [32:0]  mon_exp_w, mon_got_w;
    string        mon_nm;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            mon_got = {ctrl_m, inst_cnt, cyc_cnt};
            total++;
            if (mon_got !== mon_exp) begin
                bad++;
                $display("FAIL %s: got st/ctrl=%h inst=%0d cyc=%0d, want st/ctrl=%h inst=%0d cyc=%0d",
                         mon_nm, mon_got[88:64], mon_got[63:32], mon_got[31:0],
                         mon_exp[88:64], mon_exp[63:32], mon_exp[31:0]);
            end
            mon_exp_w = {mon_exp[88:64], mon_exp[35:32], mon_exp[3:0]};
            mon_got_w = {ctrl_w, inst_cnt_w, cyc_cnt_w};
            total++;
            if (mon_got_w !== mon_exp_w) begin
                bad++;
                $display("FAIL %s.w4: got st/ctrl=%h inst=%0d cyc=%0d, want st/ctrl=%h inst=%0d cyc=%0d",
                         mon_nm, mon_got_w[32:8], mon_got_w[7:4], mon_got_w[3:0],
                         mon_exp_w[32:8], mon_exp_w[7:4], mon_exp_w[3:0]);
            end
        end
    end

    // ---------------- driver helpers ----------------
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Select field packing: {extSZ, A, B, ctrl, W, din, pc}
    function automatic logic [11:0] sl(input logic e, input logic a, input logic [1:0] b,
                                       input logic [1:0] c, input logic [1:0] w,
                                       input logic [1:0] d, input logic [1:0] p);
        return {e, a, b, c, w, d, p};
    endfunction

    // Applies one cycle of inputs, queues the expected outputs for that cycle,
    // then advances the bench's own counter model across the clock edge.
    task automatic drive(input string nm, input logic rs, input logic rn,
                         input logic [2:0] o, input logic z, input logic dr,
                         input logic [3:0] st, input logic [7:0] en,
                         input logic [11:0] s, input logic il, input logic inc);
        logic [7:0] en_e;
        logic       il_e;
        rst      = rs;
        run      = rn;
        op       = o;
        ZF       = z;
        dm_ready = dr;
        en_e     = rs ? en : 8'h00;
        il_e     = rs ? il : 1'b0;
        exp_q.push_back({st, en_e, s, il_e, inst_m, cyc_m});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        if (!rs) begin
            cyc_m  = '0;
            inst_m = '0;
        end else begin
            cyc_m = cyc_m + 32'd1;
            if (inc) inst_m = inst_m + 32'd1;
        end
    endtask

    task automatic t_fetch(input string nm, input logic [2:0] o);
        drive({nm, ".fetch"}, 1, 1, o, rb(), rb(), 4'd0, 8'b1100_0000,
              sl(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1), 0, 0);
    endtask

    task automatic t_decode(input string nm, input logic [2:0] o, input logic il);
        drive({nm, ".decode"}, 1, rb(), o, rb(), rb(), 4'd1, 8'b0011_0000,
              sl(1, 0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0), il, 0);
    endtask

    task automatic t_memcalc(input string nm, input logic [2:0] o);
        drive({nm, ".memcalc"}, 1, rb(), o, rb(), rb(), 4'd2, 8'b0000_1000,
              sl(1, 1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0), 0, 0);
    endtask

    task automatic do_addu();
        t_fetch("addu", 3'd0);
        t_decode("addu", 3'd0, 0);
        drive("addu.rexec", 1, rb(), 3'd0, rb(), rb(), 4'd6, 8'b0000_1000,
              sl(0, 1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0), 0, 0);
        drive("addu.rfinish", 1, rb(), 3'd0, rb(), rb(), 4'd7, 8'b0000_0001,
              sl(0, 0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0), 0, 1);
    endtask

    task automatic do_subu();
        t_fetch("subu", 3'd1);
        t_decode("subu", 3'd1, 0);
        drive("subu.rexec", 1, rb(), 3'd1, rb(), rb(), 4'd6, 8'b0000_1000,
              sl(0, 1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0), 0, 0);
        drive("subu.rfinish", 1, rb(), 3'd1, rb(), rb(), 4'd7, 8'b0000_0001,
              sl(0, 0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0), 0, 1);
    endtask

    task automatic do_ori();
        t_fetch("ori", 3'd2);
        t_decode("ori", 3'd2, 0);
        drive("ori.orexec", 1, rb(), 3'd2, rb(), rb(), 4'd8, 8'b0000_1000,
              sl(0, 1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0), 0, 0);
        drive("ori.orfinish", 1, rb(), 3'd2, rb(), rb(), 4'd9, 8'b0000_0001,
              sl(0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0), 0, 1);
    endtask

    task automatic do_lw(input int waits);
        t_fetch("lw", 3'd3);
        t_decode("lw", 3'd3, 0);
        t_memcalc("lw", 3'd3);
        for (int i = 0; i < waits; i++)
            drive("lw.memload_wait", 1, rb(), 3'd3, rb(), 0, 4'd3, 8'b0000_0000,
                  sl(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 0, 0);
        drive("lw.memload_done", 1, rb(), 3'd3, rb(), 1, 4'd3, 8'b0000_0100,
              sl(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 0, 0);
        drive("lw.regwrite", 1, rb(), 3'd3, rb(), rb(), 4'd5, 8'b0000_0001,
              sl(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 0, 1);
    endtask

    task automatic do_sw(input int waits);
        t_fetch("sw", 3'd4);
        t_decode("sw", 3'd4, 0);
        t_memcalc("sw", 3'd4);
        for (int i = 0; i < waits; i++)
            drive("sw.memwrite_wait", 1, rb(), 3'd4, rb(), 0, 4'd4, 8'b0000_0010,
                  sl(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 0, 0);
        drive("sw.memwrite_done", 1, rb(), 3'd4, rb(), 1, 4'd4, 8'b0000_0010,
              sl(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 0, 1);
    endtask

    task automatic do_beq(input logic z);
        t_fetch("beq", 3'd5);
        t_decode("beq", 3'd5, 0);
        drive(z ? "beq.taken" : "beq.not_taken", 1, rb(), 3'd5, z, rb(), 4'd10,
              z ? 8'b1000_0000 : 8'b0000_0000,
              sl(0, 1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0), 0, 1);
    endtask

    task automatic do_jal();
        t_fetch("jal", 3'd6);
        t_decode("jal", 3'd6, 0);
        drive("jal.jafinish", 1, rb(), 3'd6, rb(), rb(), 4'd11, 8'b1000_0001,
              sl(0, 0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2), 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b0;
        run      = 1'b0;
        op       = 3'd0;
        ZF       = 1'b0;
        dm_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++)
            drive("reset_hold", 0, 0, 3'($urandom_range(0, 7)), rb(), rb(), 4'd0,
                  8'b0000_0000, sl(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 0, 0);

        do_addu();
        do_subu();
        do_lw(2);
        do_sw(1);
        do_beq(1'b1);
        do_beq(1'b0);
        do_jal();
        do_ori();

        t_fetch("illegal", 3'd7);
        t_decode("illegal", 3'd7, 1);

        for (int i = 0; i < 2; i++)
            drive("stall", 1, 0, 3'($urandom_range(0, 7)), rb(), rb(), 4'd0,
                  8'b0000_0000, sl(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 0, 0);

        t_fetch("abandon", 3'd0);
        t_decode("abandon", 3'd0, 0);
        drive("abandon.reset", 0, 1, 3'd0, rb(), rb(), 4'd6, 8'b0000_1000,
              sl(0, 1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0), 0, 0);
        do_ori();
        do_lw(0);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
